fizzbuzz_line_tx: RTL and testbench

Downstream formatter for the FizzBuzz counter's `fizz`/`buzz`/`fizzbuzz` flags. It accepts one flag set per event over a valid/ready handshake and keeps a BCD event index in step with the upstream counter. For each event it emits one ASCII line as a byte stream with valid/ready backpressure: "FizzBuzz", "Fizz", "Buzz", or the decimal index, followed by a line terminator. It feeds the UART/log byte sink.

---
 rtl/fizzbuzz_line_tx_if.sv | 22 ++
 rtl/fizzbuzz_line_tx.sv | 190 +++++++++++++++++++
 tb/tb_fizzbuzz_line_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fizzbuzz_line_tx_if.sv
// Handshake bundle between the FizzBuzz flag producer, the line formatter and the byte sink.
// The master side drives flags and out_ready; the slave side is the formatter.
interface fizzbuzz_line_tx_if;
   logic       in_valid;
   logic       in_ready;
   logic       fizz;
   logic       buzz;
   logic       fizzbuzz;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   modport master (
      output in_valid, fizz, buzz, fizzbuzz, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, fizz, buzz, fizzbuzz, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fizzbuzz_line_tx.sv
// Formats one FizzBuzz flag set per event into an ASCII line on a valid/ready byte stream.
// Define FIZZBUZZ_LINE_TX_CRLF_EN to terminate lines with CR LF instead of LF alone.
module fizzbuzz_line_tx #(
   parameter int MAX_CYCLES = 100,
   parameter int DIGITS     = 3
) (
   input logic               clk,
   input logic               resetn,
   fizzbuzz_line_tx_if.slave bus
);

   localparam int IW = DIGITS * 4;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WORD,
      NUM,
`ifdef FIZZBUZZ_LINE_TX_CRLF_EN
      CR,
`endif
      LF
   } state_t;

   typedef struct packed {
      logic fizz;
      logic buzz;
      logic fizzbuzz;
   } flags_t;

`ifdef FIZZBUZZ_LINE_TX_CRLF_EN
   localparam state_t     TERM_STATE = CR;
   localparam logic [7:0] TERM_BYTE  = 8'h0D;
`else
   localparam state_t     TERM_STATE = LF;
   localparam logic [7:0] TERM_BYTE  = 8'h0A;
`endif

   // Elaboration-time BCD conversion by repeated subtraction.
   function automatic logic [IW-1:0] to_bcd(input int value);
      logic [IW-1:0] r;
      int            rem;
      int            place;
      r   = '0;
      rem = value;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         place = 1;
         for (int k = 0; k < d; k++) place = place * 10;
         for (int k = 0; k < 10; k++) begin
            if (rem >= place) begin
               rem = rem - place;
               r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [IW-1:0] bcd_inc(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (carry) begin
            if (r[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // "Buzz" is the tail of "FizzBuzz", so one table serves all three words.
   function automatic logic [7:0] word_char(input logic [2:0] p);
      case (p)
         3'd0:    return 8'h46;
         3'd1:    return 8'h69;
         3'd4:    return 8'h42;
         3'd5:    return 8'h75;
         default: return 8'h7A;
      endcase
   endfunction

   localparam logic [IW-1:0] LAST_IDX = to_bcd(MAX_CYCLES - 1);

   state_t        state;
   flags_t        flags;
   logic [IW-1:0] idx;
   logic [IW-1:0] snap;
   logic [2:0]    pos;
   logic [DW-1:0] dpos;
   logic [IW-1:0] next_idx;
   logic [DW-1:0] msd;
   logic [2:0]    word_end;

   always_comb begin
      next_idx = (idx == LAST_IDX) ? '0 : bcd_inc(idx);
      msd      = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (idx[d*4 +: 4] != 4'd0) msd = DW'(d);
      end
      word_end = (flags.fizzbuzz | (flags.fizz & flags.buzz)) ? 3'd7 :
                 flags.fizz ? 3'd3 : 3'd7;
   end

   // NOTE: every register here uses <= so all of them update together from pre-edge values;
   // the async reset clears the whole datapath, so the line in flight vanishes at once.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         flags         <= '0;
         idx           <= '0;
         snap          <= '0;
         pos           <= '0;
         dpos          <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_data  <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  flags         <= '{fizz: bus.fizz, buzz: bus.buzz, fizzbuzz: bus.fizzbuzz};
                  snap          <= idx;
                  idx           <= next_idx;
                  bus.in_ready  <= 1'b0;
                  bus.out_valid <= 1'b1;
                  if (bus.fizzbuzz || (bus.fizz && bus.buzz) || bus.fizz) begin
                     state        <= WORD;
                     pos          <= 3'd0;
                     bus.out_data <= word_char(3'd0);
                  end else if (bus.buzz) begin
                     state        <= WORD;
                     pos          <= 3'd4;
                     bus.out_data <= word_char(3'd4);
                  end else begin
                     state        <= NUM;
                     dpos         <= msd;
                     bus.out_data <= {4'h3, idx[msd*4 +: 4]};
                  end
               end
            end
            WORD: begin
               if (bus.out_ready) begin
                  if (pos == word_end) begin
                     state        <= TERM_STATE;
                     bus.out_data <= TERM_BYTE;
                  end else begin
                     pos          <= pos + 3'd1;
                     bus.out_data <= word_char(pos + 3'd1);
                  end
               end
            end
            NUM: begin
               if (bus.out_ready) begin
                  if (dpos == '0) begin
                     state        <= TERM_STATE;
                     bus.out_data <= TERM_BYTE;
                  end else begin
                     dpos         <= dpos - DW'(1);
                     bus.out_data <= {4'h3, snap[(dpos - DW'(1))*4 +: 4]};
                  end
               end
            end
`ifdef FIZZBUZZ_LINE_TX_CRLF_EN
            CR: begin
               if (bus.out_ready) begin
                  state        <= LF;
                  bus.out_data <= 8'h0A;
               end
            end
`endif
            LF: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.out_data  <= 8'h00;
                  bus.in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fizzbuzz_line_tx.sv
// Directed bench for fizzbuzz_line_tx: line contents, backpressure, index wrap and reset mid-line.
// Terminator expectations follow FIZZBUZZ_LINE_TX_CRLF_EN.
module tb_fizzbuzz_line_tx;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fizzbuzz_line_tx_if bus ();

   fizzbuzz_line_tx #(.MAX_CYCLES(100), .DIGITS(3)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef logic [7:0] bq_t[$];

   function automatic bq_t line_bytes(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
`ifdef FIZZBUZZ_LINE_TX_CRLF_EN
      q.push_back(8'h0D);
`endif
      q.push_back(8'h0A);
      return q;
   endfunction

   function automatic string expected_line(input int n);
      if (n % 15 == 0) return "FizzBuzz";
      if (n % 3 == 0)  return "Fizz";
      if (n % 5 == 0)  return "Buzz";
      return $sformatf("%0d", n);
   endfunction

   task automatic accept(input string name, input logic f, input logic b, input logic fb);
      int waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_wait: in_ready=%b required 1", name, bus.in_ready);
      end
      bus.fizz      = f;
      bus.buzz      = b;
      bus.fizzbuzz  = fb;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.fizz     = 1'b0;
      bus.buzz     = 1'b0;
      bus.fizzbuzz = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: in_ready=%b required 0", name, bus.in_ready);
      end
   endtask

   // Checks the byte currently presented and each following one, then the return to idle.
   task automatic drain_line(input string name, input bq_t exp);
      for (int i = 0; i < exp.size(); i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i]) begin
            errors++;
            $display("FAIL %s byte%0d: valid=%b data=%h required valid=1 data=%h",
                     name, i, bus.out_valid, bus.out_data, exp[i]);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s end: out_valid=%b in_ready=%b required 0 1",
                  name, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic send_line(input string name, input logic f, input logic b, input logic fb,
                            input bq_t exp);
      accept(name, f, b, fb);
      drain_line(name, exp);
   endtask

   task automatic send_event(input int n);
      send_line($sformatf("event%0d", n), (n % 3 == 0), (n % 5 == 0), (n % 15 == 0),
                line_bytes(expected_line(n)));
   endtask

   task automatic test_reset;
      bus.in_valid  = 1'b0;
      bus.fizz      = 1'b0;
      bus.buzz      = 1'b0;
      bus.fizzbuzz  = 1'b0;
      bus.out_ready = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h required 1 0 00",
                  bus.in_ready, bus.out_valid, bus.out_data);
      end
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic test_first_event;
      bq_t q = '{8'h46, 8'h69, 8'h7A, 8'h7A, 8'h42, 8'h75, 8'h7A, 8'h7A};
`ifdef FIZZBUZZ_LINE_TX_CRLF_EN
      q.push_back(8'h0D);
`endif
      q.push_back(8'h0A);
      send_line("first_fizzbuzz", 1'b1, 1'b1, 1'b1, q);
   endtask

   task automatic test_numbers;
      string lines[16] = '{"FizzBuzz", "1", "2", "Fizz", "4", "Buzz", "Fizz", "7", "8",
                           "Fizz", "Buzz", "11", "Fizz", "13", "14", "FizzBuzz"};
      for (int n = 1; n < 16; n++) begin
         send_line($sformatf("num%0d", n), (n % 3 == 0), (n % 5 == 0), (n % 15 == 0),
                   line_bytes(lines[n]));
      end
   endtask

   task automatic test_backpressure;
      bq_t rest;
      for (int n = 16; n < 20; n++) send_event(n);
      accept("bp", 1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h42) begin
         errors++;
         $display("FAIL bp first: valid=%b data=%h required 1 42", bus.out_valid, bus.out_data);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h75 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp hold%0d: valid=%b data=%h in_ready=%b required 1 75 0",
                     i, bus.out_valid, bus.out_data, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      rest = line_bytes("uzz");
      rest[0] = 8'h75;
      drain_line("bp resume", rest);
   endtask

   task automatic test_wrap;
      for (int n = 21; n < 99; n++) send_event(n);
      send_line("idx99", 1'b0, 1'b0, 1'b0, line_bytes("99"));
      send_line("idx0_wrap", 1'b1, 1'b1, 1'b1, line_bytes("FizzBuzz"));
      for (int n = 1; n < 100; n++) send_event(n);
      send_line("idx0_noflags", 1'b0, 1'b0, 1'b0, line_bytes("0"));
   endtask

   task automatic test_reset_mid;
      accept("rst_mid", 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_data !== 8'h7A) begin
         errors++;
         $display("FAIL rst_mid z: data=%h required 7a", bus.out_data);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid async: out_valid=%b in_ready=%b required 0 1",
                  bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      send_line("after_reset", 1'b0, 1'b0, 1'b0, line_bytes("0"));
   endtask

   task automatic test_crlf_line;
      for (int n = 1; n < 7; n++) send_event(n);
      send_line("idx7", 1'b0, 1'b0, 1'b0, line_bytes("7"));
   endtask

   task automatic test_back_to_back;
      bq_t first = line_bytes("8");
      bus.fizz      = 1'b0;
      bus.buzz      = 1'b0;
      bus.fizzbuzz  = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < first.size(); i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== first[i]) begin
            errors++;
            $display("FAIL b2b byte%0d: valid=%b data=%h required valid=1 data=%h",
                     i, bus.out_valid, bus.out_data, first[i]);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b gap: out_valid=%b in_ready=%b required 0 1",
                  bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drain_line("b2b second", line_bytes("9"));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_event();
      test_numbers();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_crlf_line();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
